arb_mux: RTL and testbench
==========================

# arb_mux

Parametrised N-input registered arbitrating multiplexer, the successor to the combinational `mux4`. It generalises data width and input count, and replaces the external `sel` with internal arbitration, either round-robin or fixed-priority. Each input and the output use valid/ready handshakes, and there is a one-entry output register. The block sits between multiple requesters (for example bus masters or writeback sources) and a single downstream consumer in the MCU datapath.

## Interface
Parameters:
- DATA_WIDTH, 64, width of each data channel
- N_IN, 4, number of input channels (legal range 2..16; need not be a power of two)
- SEL_W, $clog2(N_IN), width of the channel index
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  N_IN*DATA_WIDTH  packed inputs; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_valid  input  N_IN  per-channel request
- in_ready  output  N_IN  per-channel accept; at most one bit high per cycle
- out_data  output  DATA_WIDTH  registered selected data
- out_sel  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  out_data/out_sel hold a valid beat
- out_ready  input  1  downstream accept

## Operation
- Transfer definitions:
  - An input transfer occurs on channel i when in_valid[i] && in_ready[i].
  - An output transfer occurs when out_valid && out_ready.
- load_en = !out_valid || out_ready. The output register can accept a new beat when it is empty or is being drained in the same cycle.
- Grant selection (combinational, among channels with in_valid high):
  - RR_MODE=1: search starts at (last_grant+1) mod N_IN and wraps upward; the first valid channel wins.
  - RR_MODE=0: the lowest valid index wins. last_grant is ignored.
- in_ready = one-hot(grant) when load_en && |in_valid; otherwise all zero.
- On an input transfer:
  - out_data <= selected channel's data, out_sel <= grant, out_valid <= 1.
  - last_grant <= grant, in RR mode only.
- Output transfer with no input transfer: out_valid <= 0. out_data and out_sel hold their last values.
- Output transfer and input transfer in the same cycle: the new beat replaces the old one. out_valid stays 1, giving full throughput of 1 beat/cycle.
- Output stalled (out_valid && !out_ready): out_data, out_sel and out_valid hold stable, all in_ready are 0, and last_grant does not change.
- last_grant changes only on an input transfer. A requester that drops in_valid before being granted loses nothing.
- No input's data is ever dropped or duplicated. Each input transfer produces exactly one output beat.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - out_valid=0, out_data=0, out_sel=0, in_ready=0.
  - last_grant=N_IN-1, so the first RR search starts at channel 0.
- Latency: an input transfer in cycle t produces out_valid=1 with that data from cycle t+1.
- in_ready depends combinationally on in_valid, out_valid and out_ready. There is no combinational path from in_data to any output.
- Round-robin fairness: with all N_IN channels continuously valid and out_ready=1, the grant sequence is 0,1,…,N_IN-1,0,… with no channel repeated within N_IN consecutive grants.
- Wrap-around: the search index wraps from N_IN-1 to 0 via modulo N_IN. It never selects an index >= N_IN, including when N_IN is not a power of two.
- Reset asserted mid-stall: the pending beat is discarded, out_valid=0 immediately, and arbitration restarts from channel 0 after rst_n deasserts.
- Inputs must hold in_valid and in_data stable until accepted. This is an upstream obligation; the block does not check it.

## Test plan
- Single requester:
  - Stimulus: N_IN=4, DATA_WIDTH=64, in_data ch i = 64'h0..03 + i; only in_valid[2]=1 for 3 cycles; out_ready=1.
  - Required response: in_ready=4'b0100 each cycle; out_data=64'h2, out_sel=2 from the next cycle; out_valid drops 1 cycle after in_valid drops.
- Round-robin rotation:
  - Stimulus: RR_MODE=1, all in_valid=1 for 9 cycles, out_ready=1, from reset.
  - Required response: out_sel sequence 0,1,2,3,0,1,2,3,0; one beat per cycle.
- Fixed priority:
  - Stimulus: RR_MODE=0, in_valid=4'b1010 held.
  - Required response: every grant goes to channel 1; channel 3 is never granted while channel 1 is valid.
- Backpressure:
  - Stimulus: all valid; out_ready=0 for 5 cycles after the first beat loads (out_sel=0).
  - Required response: out_data/out_sel/out_valid stable at ch0, in_ready=0 throughout; after out_ready=1 the next grant is ch1.
- Non-power-of-two wrap:
  - Stimulus: N_IN=3, all valid, 7 beats.
  - Required response: out_sel sequence 0,1,2,0,1,2,0; out_sel never equals 3.
- Reset mid-operation:
  - Stimulus: pulse rst_n low while out_valid=1 and out_ready=0.
  - Required response: out_valid, out_data and out_sel go to 0 without a clock edge; the first post-reset grant with all inputs valid is channel 0.

Source files
------------

// File: rtl/arb_mux.sv
// arb_mux: N-input arbitrating mux with one registered output beat.
// Round-robin or fixed-priority grant, valid/ready on every side.
module arb_mux #(
  parameter int DATA_WIDTH = 64,
  parameter int N_IN       = 4,
  parameter int SEL_W      = $clog2(N_IN),
  parameter bit RR_MODE    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_IN*DATA_WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]            in_valid,
  output logic [N_IN-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]           out_sel,
  output logic                       out_valid,
  input  logic                       out_ready
);

  logic [SEL_W-1:0]      last_grant;
  logic [SEL_W-1:0]      grant;
  logic [SEL_W:0]        idx;
  logic                  found;
  logic                  load_en;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [N_IN-1:0]       one;

  assign load_en = !out_valid || out_ready;
  assign one     = {{(N_IN-1){1'b0}}, 1'b1};

  // Pick the winning channel among those currently requesting.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    if (RR_MODE) begin
      for (int k = 1; k <= N_IN; k++) begin
        idx = {1'b0, last_grant} + (SEL_W+1)'(k);
        if (idx >= (SEL_W+1)'(N_IN))
          idx = idx - (SEL_W+1)'(N_IN);
        if (!found && in_valid[idx[SEL_W-1:0]]) begin
          grant = idx[SEL_W-1:0];
          found = 1'b1;
        end
      end
    end else begin
      for (int i = N_IN-1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant = SEL_W'(i);
          found = 1'b1;
        end
      end
    end
  end

  // Accept strobe goes only to the granted channel, when we can load.
  always_comb begin
    in_ready = '0;
    if (load_en && found)
      in_ready = one << grant;
  end

  assign xfer = load_en && found;

  // Route the granted channel's data to the output register input.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant == SEL_W'(i))
        sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Output register: load on input transfer, empty on a bare drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_data  <= sel_data;
      out_sel   <= grant;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Remember the last winner so round-robin resumes after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant <= SEL_W'(N_IN-1);
    else if (xfer && RR_MODE)
      last_grant <= grant;
  end

endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: scoreboard bench for arb_mux.
// Three instances: 4-way RR, 4-way fixed priority, 3-way RR.
module tb_arb_mux;

  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [71:0] qa[$];
  logic [71:0] qb[$];
  logic [71:0] qc[$];

  logic [4*DW-1:0] a_data, b_data;
  logic [3*DW-1:0] c_data;
  logic [3:0] a_valid, a_ready, b_valid, b_ready;
  logic [2:0] c_valid, c_ready;
  logic [DW-1:0] a_odata, b_odata, c_odata;
  logic [1:0] a_osel, b_osel, c_osel;
  logic a_ovalid, b_ovalid, c_ovalid;
  logic a_oready, b_oready, c_oready;

  arb_mux #(.DATA_WIDTH(DW), .N_IN(4), .RR_MODE(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .out_data(a_odata), .out_sel(a_osel),
    .out_valid(a_ovalid), .out_ready(a_oready));

  arb_mux #(.DATA_WIDTH(DW), .N_IN(4), .RR_MODE(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .out_data(b_odata), .out_sel(b_osel),
    .out_valid(b_ovalid), .out_ready(b_oready));

  arb_mux #(.DATA_WIDTH(DW), .N_IN(3), .RR_MODE(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n),
    .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .out_data(c_odata), .out_sel(c_osel),
    .out_valid(c_ovalid), .out_ready(c_oready));

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic pop(string nm, inout logic [71:0] q[$],
                     input logic [1:0] sel, input logic [63:0] dat);
    logic [71:0] e;
    if (q.size() == 0) begin
      total++;
      $display("FAIL %s_extra: got beat sel %0d data %0h expected none",
               nm, sel, dat);
    end else begin
      e = q.pop_front();
      chk({nm, "_sel"}, 64'(sel), 64'(e[71:64]));
      chk({nm, "_data"}, dat, e[63:0]);
    end
  endtask

  always @(negedge clk)
    if (rst_n && a_ovalid && a_oready) pop("a", qa, a_osel, a_odata);

  always @(negedge clk)
    if (rst_n && b_ovalid && b_oready) pop("b", qb, b_osel, b_odata);

  always @(negedge clk)
    if (rst_n && c_ovalid && c_oready) begin
      chk("c_sel_range", 64'(c_osel < 2'd3), 64'd1);
      pop("c", qc, c_osel, c_odata);
    end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_valid = '0; b_valid = '0; c_valid = '0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      a_data[i*DW +: DW] = 64'(i);
      b_data[i*DW +: DW] = 64'h100 + 64'(i);
    end
    for (int i = 0; i < 3; i++)
      c_data[i*DW +: DW] = 64'h30 + 64'(i);
    a_valid = '0; b_valid = '0; c_valid = '0;
    a_oready = 1'b1; b_oready = 1'b1; c_oready = 1'b1;

    // reset values while held
    #7;
    chk("rst_valid", 64'(a_ovalid), 64'd0);
    chk("rst_data", a_odata, 64'd0);
    chk("rst_sel", 64'(a_osel), 64'd0);
    chk("rst_ready", 64'(a_ready), 64'd0);
    cyc();
    rst_n = 1'b1;

    // single requester on channel 2
    a_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      qa.push_back({8'd2, 64'd2});
      @(negedge clk);
      chk("single_ready", 64'(a_ready), 64'b0100);
      cyc();
    end
    a_valid = '0;
    @(negedge clk);
    chk("single_tail_valid", 64'(a_ovalid), 64'd1);
    cyc();
    @(negedge clk);
    chk("single_drop_valid", 64'(a_ovalid), 64'd0);

    // round-robin rotation from reset
    do_reset();
    a_valid = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      qa.push_back({8'(i % 4), 64'(i % 4)});
      @(negedge clk);
      if (i > 0) chk("rr_full_rate", 64'(a_ovalid), 64'd1);
      cyc();
    end
    a_valid = '0;
    cyc();

    // backpressure
    do_reset();
    a_valid = 4'b1111;
    a_oready = 1'b0;
    @(negedge clk);
    chk("bp_first_ready", 64'(a_ready), 64'b0001);
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready_zero", 64'(a_ready), 64'd0);
      chk("bp_valid", 64'(a_ovalid), 64'd1);
      chk("bp_sel", 64'(a_osel), 64'd0);
      chk("bp_data", a_odata, 64'd0);
      cyc();
    end
    qa.push_back({8'd0, 64'd0});
    qa.push_back({8'd1, 64'd1});
    a_oready = 1'b1;
    @(negedge clk);
    chk("bp_next_grant", 64'(a_ready), 64'b0010);
    cyc();
    a_valid = '0;
    cyc();

    // reset during a stall
    a_valid = 4'b1000;
    a_oready = 1'b0;
    cyc();
    a_valid = '0;
    @(negedge clk);
    chk("mid_pre_valid", 64'(a_ovalid), 64'd1);
    chk("mid_pre_sel", 64'(a_osel), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(a_ovalid), 64'd0);
    chk("mid_rst_data", a_odata, 64'd0);
    chk("mid_rst_sel", 64'(a_osel), 64'd0);
    cyc();
    rst_n = 1'b1;
    a_valid = 4'b1111;
    a_oready = 1'b1;
    qa.push_back({8'd0, 64'd0});
    @(negedge clk);
    chk("mid_post_grant", 64'(a_ready), 64'b0001);
    cyc();
    a_valid = '0;
    cyc();

    // fixed priority, channels 1 and 3 requesting
    b_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      qb.push_back({8'd1, 64'h101});
      @(negedge clk);
      chk("fp_ready", 64'(b_ready), 64'b0010);
      cyc();
    end
    b_valid = 4'b1000;
    qb.push_back({8'd3, 64'h103});
    @(negedge clk);
    chk("fp_ch3_alone", 64'(b_ready), 64'b1000);
    cyc();
    b_valid = '0;
    cyc();

    // three-way round robin wrap
    c_valid = 3'b111;
    for (int i = 0; i < 7; i++) begin
      qc.push_back({8'(i % 3), 64'h30 + 64'(i % 3)});
      cyc();
    end
    c_valid = '0;
    cyc();
    cyc();

    chk("a_queue_empty", 64'(qa.size()), 64'd0);
    chk("b_queue_empty", 64'(qb.size()), 64'd0);
    chk("c_queue_empty", 64'(qc.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
